hdlc_tx_scheduler: RTL

Round-robin frame scheduler that shares one HDLC transmitter (`HDLC_TOP` TX side) between `NUM_SRC` frame sources. It selects a source with a complete frame queued and issues `TxStart`. It then streams that source's bytes on `TxInputReq`, signals end of frame through `TxEmpty`, and enforces a programmable inter-frame gap. It also supervises the transmitter with a start timeout and supports a host abort.

---
 rtl/hdlc_tx_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hdlc_tx_scheduler.sv
// hdlc_tx_scheduler: round-robin arbiter that feeds complete frames from NUM_SRC
// sources into one HDLC transmitter, with inter-frame gap, start timeout and abort.
module hdlc_tx_scheduler #(
    parameter int NUM_SRC       = 4,
    parameter int IDX_W         = 2,
    parameter int START_TIMEOUT = 64
) (
    input  logic                 Clk,
    input  logic                 Rstn,
    input  logic                 En,
    input  logic [15:0]          GapCycles,
    input  logic                 AbortReq,
    input  logic [NUM_SRC-1:0]   SrcReq,
    input  logic [NUM_SRC*8-1:0] SrcData,
    input  logic [NUM_SRC-1:0]   SrcLast,
    output logic [NUM_SRC-1:0]   SrcRd,
    output logic [NUM_SRC-1:0]   SrcFlush,
    output logic [7:0]           TxInputData,
    input  logic                 TxInputReq,
    output logic                 TxEmpty,
    output logic                 TxStart,
    output logic                 TxAbort,
    input  logic                 TxBusy,
    output logic [NUM_SRC-1:0]   Grant,
    output logic [IDX_W-1:0]     GrantIdx,
    output logic                 Busy,
    output logic                 FrameDone,
    output logic                 FrameAbort,
    output logic                 ErrTimeout
);
    localparam int TO_W = $clog2(START_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, ABORT, GAP} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic             busy_seen;
    logic [TO_W-1:0]  to_cnt;
    logic [15:0]      gap_left;
    logic [15:0]      gap_load;
    logic             last_pop;
    logic             timed_out;

    // Scan downward so the last hit is the nearest set bit after ptr.
    always_comb begin
        win_idx = '0;
        cand = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_SRC);
            if (SrcReq[cand]) win_idx = cand;
        end
    end

    assign last_pop    = TxInputReq & SrcLast[GrantIdx];
    assign timed_out   = !(busy_seen | TxBusy) && to_cnt == TO_LAST;
    assign gap_load    = (GapCycles == 16'd0) ? 16'd0 : GapCycles - 16'd1;
    assign SrcRd       = (state == STREAM && TxInputReq && !AbortReq) ? Grant : '0;
    assign TxInputData = SrcData[{GrantIdx, 3'b000} +: 8];
    assign TxEmpty     = !(state == START || state == STREAM);
    assign Busy        = state != IDLE;

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state      <= IDLE;
            ptr        <= IDX_W'(NUM_SRC - 1);
            Grant      <= '0;
            GrantIdx   <= '0;
            busy_seen  <= 1'b0;
            to_cnt     <= '0;
            gap_left   <= '0;
            TxStart    <= 1'b0;
            TxAbort    <= 1'b0;
            SrcFlush   <= '0;
            FrameDone  <= 1'b0;
            FrameAbort <= 1'b0;
            ErrTimeout <= 1'b0;
        end else begin
            TxStart    <= 1'b0;
            TxAbort    <= 1'b0;
            SrcFlush   <= '0;
            FrameDone  <= 1'b0;
            FrameAbort <= 1'b0;
            ErrTimeout <= 1'b0;
            case (state)
                IDLE: if (En && |SrcReq) begin
                    state    <= START;
                    ptr      <= win_idx;
                    GrantIdx <= win_idx;
                    Grant    <= NUM_SRC'(1) << win_idx;
                end
                START: if (AbortReq) begin
                    TxAbort  <= 1'b1;
                    SrcFlush <= Grant;
                    state    <= ABORT;
                end else begin
                    TxStart   <= 1'b1;
                    busy_seen <= 1'b0;
                    to_cnt    <= '0;
                    state     <= STREAM;
                end
                STREAM, DRAIN: begin
                    if (TxBusy) busy_seen <= 1'b1;
                    else if (!busy_seen) to_cnt <= to_cnt + 1'b1;
                    if (AbortReq || timed_out) begin
                        TxAbort    <= 1'b1;
                        SrcFlush   <= Grant;
                        ErrTimeout <= timed_out;
                        state      <= ABORT;
                    end else if (state == STREAM && last_pop) begin
                        state <= DRAIN;
                    end else if (state == DRAIN && busy_seen && !TxBusy) begin
                        FrameDone <= 1'b1;
                        Grant     <= '0;
                        GrantIdx  <= '0;
                        gap_left  <= gap_load;
                        state     <= GAP;
                    end
                end
                ABORT: if (!TxBusy) begin
                    FrameAbort <= 1'b1;
                    Grant      <= '0;
                    GrantIdx   <= '0;
                    gap_left   <= gap_load;
                    state      <= GAP;
                end
                GAP: if (gap_left == 16'd0) state <= IDLE;
                     else gap_left <= gap_left - 16'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
